// File: rtl/word_mem_responder.sv
// Byte-serial word memory target: serves one big-endian 32-bit word as four byte beats per transfer.
// Optional macro RESP_ERR_EN adds an err output and treats out-of-range addresses as flagged no-op transfers.
module word_mem_responder #(
   parameter int WORDS = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       rw_select,
   input  logic [7:0] address,
   input  logic [7:0] data_in,
   output logic       enable,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       busy
`ifdef RESP_ERR_EN
   ,
   output logic       err
`endif
);

   localparam int DEPTH = WORDS * 4;
   localparam int BW    = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      RD_LAT = 2'd2,
      READ   = 2'd3
   } state_t;

   state_t        state_r, state_s;
   logic [1:0]    beat_r, beat_s;
   logic [BW-1:0] base_r, base_s;
   logic          oor_r, oor_s;
   logic [7:0]    data_out_r, data_out_s;
   logic          data_valid_r, data_valid_s;
   logic          active_r;
   logic          ram_we_s;
   logic [BW-1:0] wr_idx_s;
   logic [BW-1:0] rd_idx_s;
   logic [7:0]    word_mod_s;
   logic [7:0]    ram [DEPTH];

   // Next-state, next-output and RAM write decode for the transfer FSM
   always_comb begin
      state_s      = state_r;
      beat_s       = beat_r;
      base_s       = base_r;
      oor_s        = oor_r;
      data_out_s   = data_out_r;
      data_valid_s = 1'b0;
      ram_we_s     = 1'b0;
      wr_idx_s     = base_r | BW'(beat_r);
      rd_idx_s     = base_r;
      word_mod_s   = 8'(32'(address) % 32'(WORDS));
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = rw_select ? WRITE : RD_LAT;
               beat_s  = 2'd0;
               // Base is a multiple of 4, so OR-ing in the beat never carries into the next word
               base_s  = BW'({word_mod_s, 2'b00});
`ifdef RESP_ERR_EN
               oor_s   = (32'(address) >= 32'(WORDS));
`else
               oor_s   = 1'b0;
`endif
            end else begin
               state_s = IDLE;
            end
         end
         WRITE: begin
            ram_we_s = ~oor_r;
            beat_s   = beat_r + 2'd1;
            if (beat_r == 2'd3) begin
               state_s = IDLE;
               oor_s   = 1'b0;
            end else begin
               state_s = WRITE;
            end
         end
         RD_LAT: begin
            state_s      = READ;
            beat_s       = 2'd0;
            data_valid_s = 1'b1;
            rd_idx_s     = base_r;
            data_out_s   = oor_r ? 8'h00 : ram[rd_idx_s];
         end
         READ: begin
            if (beat_r == 2'd3) begin
               state_s = IDLE;
               oor_s   = 1'b0;
            end else begin
               state_s      = READ;
               beat_s       = beat_r + 2'd1;
               data_valid_s = 1'b1;
               rd_idx_s     = base_r | BW'(beat_r + 2'd1);
               data_out_s   = oor_r ? 8'h00 : ram[rd_idx_s];
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         beat_r       <= 2'd0;
         base_r       <= {BW{1'b0}};
         oor_r        <= 1'b0;
         data_out_r   <= 8'h00;
         data_valid_r <= 1'b0;
         active_r     <= 1'b0;
      end else begin
         state_r      <= state_s;
         beat_r       <= beat_s;
         base_r       <= base_s;
         oor_r        <= oor_s;
         data_out_r   <= data_out_s;
         data_valid_r <= data_valid_s;
         active_r     <= (state_s != IDLE);
      end
   end

   // Byte RAM write port; contents survive reset, but a beat coinciding with reset is dropped
   always_ff @(posedge clk) begin
      if (ram_we_s && !reset) begin
         ram[wr_idx_s] <= data_in;
      end
   end

   assign enable     = active_r;
   assign busy       = active_r;
   assign data_out   = data_out_r;
   assign data_valid = data_valid_r;
`ifdef RESP_ERR_EN
   assign err        = oor_r;
`endif

endmodule

// File: tb/tb_word_mem_responder.sv
// Self-checking bench for word_mem_responder: directed scenarios plus random traffic against a word-level model.
module tb_word_mem_responder;

   localparam int WORDS = 64;

   logic       clk;
   logic       reset;
   logic       start;
   logic       rw_select;
   logic [7:0] address;
   logic [7:0] data_in;
   logic       enable;
   logic [7:0] data_out;
   logic       data_valid;
   logic       busy;
`ifdef RESP_ERR_EN
   logic       err;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: one 32-bit word per address, byte 0 is the MSB
   logic [31:0] mem_w [WORDS];

   word_mem_responder #(.WORDS(WORDS)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .rw_select  (rw_select),
      .address    (address),
      .data_in    (data_in),
      .enable     (enable),
      .data_out   (data_out),
      .data_valid (data_valid),
      .busy       (busy)
`ifdef RESP_ERR_EN
      ,
      .err        (err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int widx(input logic [7:0] a);
      return int'(a) % WORDS;
   endfunction

   function automatic bit oor(input logic [7:0] a);
`ifdef RESP_ERR_EN
      return int'(a) >= WORDS;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [7:0] exp_byte(input logic [7:0] a, input int k);
      logic [31:0] w;
      if (oor(a)) return 8'h00;
      w = mem_w[widx(a)];
      return w[31-8*k -: 8];
   endfunction

   task automatic check_err(input string tag, input bit exp);
`ifdef RESP_ERR_EN
      check(tag, {31'd0, err}, {31'd0, exp});
`endif
   endtask

   // Starts at a negedge with the DUT idle; returns at a negedge with enable low.
   task automatic do_write(input logic [7:0] a, input logic [31:0] w, input int rst_beat, input bit restart);
      start = 1'b1; rw_select = 1'b1; address = a;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         start = (k == 3) && restart;
         check("wr_enable", {31'd0, enable}, 32'd1);
         check("wr_busy", {31'd0, busy}, 32'd1);
         check("wr_valid", {31'd0, data_valid}, 32'd0);
         check_err("wr_err", oor(a));
         data_in = w[31-8*k -: 8];
         if (k == rst_beat) begin
            reset = 1'b1; start = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            check("rst_enable", {31'd0, enable}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_valid", {31'd0, data_valid}, 32'd0);
            check("rst_data_out", {24'd0, data_out}, 32'd0);
            check_err("rst_err", 1'b0);
            return;
         end
         if (!oor(a)) mem_w[widx(a)][31-8*k -: 8] = w[31-8*k -: 8];
      end
      @(negedge clk);
      start = 1'b0;
      check("wr_end_enable", {31'd0, enable}, 32'd0);
      check("wr_end_busy", {31'd0, busy}, 32'd0);
      check_err("wr_end_err", 1'b0);
   endtask

   task automatic do_read(input logic [7:0] a, input bit spam);
      logic [7:0] last;
      last = 8'h00;
      start = 1'b1; rw_select = 1'b0; address = a;
      @(negedge clk);
      start = spam; address = 8'(a + 8'd1); rw_select = 1'b1;
      check("rd_lat_enable", {31'd0, enable}, 32'd1);
      check("rd_lat_busy", {31'd0, busy}, 32'd1);
      check("rd_lat_valid", {31'd0, data_valid}, 32'd0);
      check_err("rd_lat_err", oor(a));
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         start = spam;
         last = exp_byte(a, k);
         check("rd_enable", {31'd0, enable}, 32'd1);
         check("rd_busy", {31'd0, busy}, 32'd1);
         check("rd_valid", {31'd0, data_valid}, 32'd1);
         check("rd_data", {24'd0, data_out}, {24'd0, last});
         check_err("rd_err", oor(a));
      end
      @(negedge clk);
      start = 1'b0;
      check("rd_end_enable", {31'd0, enable}, 32'd0);
      check("rd_end_busy", {31'd0, busy}, 32'd0);
      check("rd_end_valid", {31'd0, data_valid}, 32'd0);
      check("rd_end_hold", {24'd0, data_out}, {24'd0, last});
      check_err("rd_end_err", 1'b0);
      if (spam) begin
         @(negedge clk);
         check("spam_no_extra", {31'd0, enable}, 32'd0);
      end
   endtask

   initial begin
      int rb;
      logic [7:0] a;
      reset = 1'b1; start = 1'b0; rw_select = 1'b0; address = 8'd0; data_in = 8'd0;
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      check("reset_enable", {31'd0, enable}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_valid", {31'd0, data_valid}, 32'd0);
      check("reset_data_out", {24'd0, data_out}, 32'd0);
      check_err("reset_err", 1'b0);
      reset = 1'b0; start = 1'b0;
      @(negedge clk);
      check("idle_enable", {31'd0, enable}, 32'd0);

      for (int i = 0; i < WORDS; i++) do_write(8'(i), $urandom, -1, 1'b0);

      do_write(8'd4, 32'hBA5E0000, -1, 1'b0);
      do_read(8'd4, 1'b0);

      do_write(8'd5, 32'hBA110000, -1, 1'b1);
      do_read(8'd5, 1'b0);

      do_read(8'd0, 1'b1);

      do_write(8'd2, 32'h11223344, -1, 1'b0);
      do_write(8'd2, 32'hAABBCCDD, 2, 1'b0);
      check("partial_model", mem_w[2], 32'hAABB3344);
      do_read(8'd2, 1'b0);

      do_write(8'd63, 32'hDEADBEEF, -1, 1'b0);
      do_read(8'd63, 1'b0);
      do_read(8'd0, 1'b0);

      do_write(8'd64, 32'h01020304, -1, 1'b0);
      do_read(8'd0, 1'b0);
      do_read(8'd64, 1'b0);
      do_read(8'd200, 1'b0);

      for (int i = 0; i < 60; i++) begin
         a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1) begin
            rb = $urandom_range(0, 7);
            do_write(a, $urandom, (rb < 4) ? rb : -1, 1'($urandom_range(0, 1)));
         end else begin
            do_read(a, 1'($urandom_range(0, 1)));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
